ahb_lite_interconnect: RTL and testbench



---
 rtl/ahb_pkg.sv | 32 +++
 rtl/ahb_lite_decoder.sv | 34 +++
 rtl/ahb_lite_interconnect.sv | 166 ++++++++++++++++
 tb/tb_ahb_lite_interconnect.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg
//   Shared types and constants for the AHB-lite interconnect:
//   - ahb_state_e : data-phase state machine encoding
//   - ERR_*       : cause codes reported on err_last
//   - HRESP_*     : response encodings
//   - OWNER_*     : data-phase owner encoding (slave index, default slave, none)
package ahb_pkg;

  localparam int AHB_ADDR_WIDTH = 32;
  localparam int AHB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } ahb_state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_DEC  = 2'd1;
  localparam logic [1:0] ERR_TO   = 2'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Owner codes 0..15 are slave indices; two extra codes above the
  // largest legal slave count mark the default slave and "no owner".
  localparam int             OWNER_W       = 5;
  localparam logic [OWNER_W-1:0] OWNER_DEFAULT = 5'd16;
  localparam logic [OWNER_W-1:0] OWNER_NONE    = 5'd17;

endpackage

// File: rtl/ahb_lite_decoder.sv
// ahb_lite_decoder
//   Combinational address decoder. Each slave i owns the window where
//   (addr & SLV_MASK[i]) == SLV_BASE[i]; on overlap the lowest index wins.
// Ports:
//   addr  in  AW       address being decoded
//   hit   out NUM_SLV  one-hot winning slave (all zero on miss)
//   miss  out 1        no window matched; default slave takes the transfer
module ahb_lite_decoder
  import ahb_pkg::*;
#(
  parameter int                    NUM_SLV  = 4,
  parameter int                    AW       = AHB_ADDR_WIDTH,
  parameter logic [NUM_SLV*AW-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                               32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLV*AW-1:0] SLV_MASK = {NUM_SLV{32'hF000_0000}}
) (
  input  logic [AW-1:0]      addr,
  output logic [NUM_SLV-1:0] hit,
  output logic               miss
);

  always_comb begin
    hit  = '0;
    miss = 1'b1;
    // Scanning upward and stopping at the first match gives lowest-index priority.
    for (int i = 0; i < NUM_SLV; i++) begin
      if (miss && ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
        hit[i] = 1'b1;
        miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ahb_lite_interconnect.sv
// ahb_lite_interconnect
//   Single-master AHB-lite fabric for NUM_SLV slaves. Decodes the address
//   phase into one-hot selects, tracks the data-phase owner and muxes its
//   response back. A built-in default slave answers unmapped addresses with
//   a two-cycle ERROR, and a wait-state timeout aborts hung slaves.
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   m_haddr/m_haddr_ctrl/m_hwrite  master address phase
//   m_hwdata                       master write data (data phase)
//   m_hready/m_hresp/m_hrdata      response to master
//   s_haddr/s_hwrite/s_hwdata      broadcast to slaves
//   s_hsel                         one-hot slave select (address phase)
//   s_hready/s_hresp/s_hrdata      per-slave responses
//   err_cnt                        saturating count of generated errors
//   err_last                       cause of the last generated error
module ahb_lite_interconnect
  import ahb_pkg::*;
#(
  parameter int                    NUM_SLV  = 4,
  parameter int                    AW       = AHB_ADDR_WIDTH,
  parameter int                    DW       = AHB_DATA_WIDTH,
  parameter logic [NUM_SLV*AW-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                               32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLV*AW-1:0] SLV_MASK = {NUM_SLV{32'hF000_0000}},
  parameter int                    TIMEOUT  = 256
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [AW-1:0]         m_haddr,
  input  logic                  m_haddr_ctrl,
  input  logic                  m_hwrite,
  input  logic [DW-1:0]         m_hwdata,
  output logic                  m_hready,
  output logic                  m_hresp,
  output logic [DW-1:0]         m_hrdata,
  output logic [AW-1:0]         s_haddr,
  output logic                  s_hwrite,
  output logic [DW-1:0]         s_hwdata,
  output logic [NUM_SLV-1:0]    s_hsel,
  input  logic [NUM_SLV-1:0]    s_hready,
  input  logic [NUM_SLV-1:0]    s_hresp,
  input  logic [NUM_SLV*DW-1:0] s_hrdata,
  output logic [15:0]           err_cnt,
  output logic [1:0]            err_last
);

  localparam int CW = $clog2(TIMEOUT);

  ahb_state_e         state;
  logic [OWNER_W-1:0] owner;
  logic [CW-1:0]      wait_cnt;

  logic [NUM_SLV-1:0] dec_hit;
  logic               dec_miss;
  logic [OWNER_W-1:0] win_idx;
  logic               sel_hready;
  logic               sel_hresp;
  logic [DW-1:0]      sel_hrdata;
  logic               accept;
  logic [15:0]        err_cnt_inc;

  ahb_lite_decoder #(
    .NUM_SLV  (NUM_SLV),
    .AW       (AW),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decoder (
    .addr (m_haddr),
    .hit  (dec_hit),
    .miss (dec_miss)
  );

  assign s_haddr  = m_haddr;
  assign s_hwrite = m_hwrite;
  assign s_hwdata = m_hwdata;
  assign s_hsel   = m_haddr_ctrl ? dec_hit : '0;

  // One-hot hit to owner index.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (dec_hit[i]) win_idx = OWNER_W'(i);
    end
  end

  // Owner response mux; only meaningful while state is DATA.
  always_comb begin
    sel_hready = 1'b1;
    sel_hresp  = HRESP_OKAY;
    sel_hrdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (owner == OWNER_W'(i)) begin
        sel_hready = s_hready[i];
        sel_hresp  = s_hresp[i];
        sel_hrdata = s_hrdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    m_hready = 1'b1;
    m_hresp  = HRESP_OKAY;
    m_hrdata = '0;
    case (state)
      DATA: begin
        m_hready = sel_hready;
        m_hresp  = sel_hresp;
        m_hrdata = sel_hrdata;
      end
      ERR1: begin
        m_hready = 1'b0;
        m_hresp  = HRESP_ERROR;
      end
      ERR2: begin
        m_hresp  = HRESP_ERROR;
      end
      default: ;
    endcase
  end

  assign accept      = m_haddr_ctrl & m_hready;
  assign err_cnt_inc = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      owner    <= OWNER_NONE;
      wait_cnt <= '0;
      err_cnt  <= '0;
      err_last <= ERR_NONE;
    end else if (accept) begin
      wait_cnt <= '0;
      if (dec_miss) begin
        state    <= ERR1;
        owner    <= OWNER_DEFAULT;
        err_cnt  <= err_cnt_inc;
        err_last <= ERR_DEC;
      end else begin
        state <= DATA;
        owner <= win_idx;
      end
    end else if (m_hready) begin
      // Transfer finished with no new request behind it.
      state <= IDLE;
      owner <= OWNER_NONE;
    end else begin
      case (state)
        DATA: begin
          // m_hready low in DATA means the owner is inserting a wait state.
          if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state    <= ERR1;
            owner    <= OWNER_DEFAULT;
            wait_cnt <= '0;
            err_cnt  <= err_cnt_inc;
            err_last <= ERR_TO;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        ERR1:    state <= ERR2;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// tb_ahb_lite_interconnect
//   Directed bench: drives master and slave signals cycle by cycle and
//   compares responses with hand-computed values at the falling edge.
module tb_ahb_lite_interconnect;

  logic         clk;
  logic         rstn;
  logic [31:0]  m_haddr;
  logic         m_haddr_ctrl;
  logic         m_hwrite;
  logic [31:0]  m_hwdata;
  logic         m_hready;
  logic         m_hresp;
  logic [31:0]  m_hrdata;
  logic [31:0]  s_haddr;
  logic         s_hwrite;
  logic [31:0]  s_hwdata;
  logic [3:0]   s_hsel;
  logic [3:0]   s_hready;
  logic [3:0]   s_hresp;
  logic [127:0] s_hrdata;
  logic [15:0]  err_cnt;
  logic [1:0]   err_last;

  int total = 0;
  int bad   = 0;

  ahb_lite_interconnect #(
    .NUM_SLV (4),
    .AW      (32),
    .DW      (32),
    .TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .m_haddr      (m_haddr),
    .m_haddr_ctrl (m_haddr_ctrl),
    .m_hwrite     (m_hwrite),
    .m_hwdata     (m_hwdata),
    .m_hready     (m_hready),
    .m_hresp      (m_hresp),
    .m_hrdata     (m_hrdata),
    .s_haddr      (s_haddr),
    .s_hwrite     (s_hwrite),
    .s_hwdata     (s_hwdata),
    .s_hsel       (s_hsel),
    .s_hready     (s_hready),
    .s_hresp      (s_hresp),
    .s_hrdata     (s_hrdata),
    .err_cnt      (err_cnt),
    .err_last     (err_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rstn         = 1'b0;
    m_haddr      = '0;
    m_haddr_ctrl = 1'b0;
    m_hwrite     = 1'b0;
    m_hwdata     = '0;
    s_hready     = 4'hF;
    s_hresp      = 4'h0;
    s_hrdata     = {32'hA000_0003, 32'hA000_0002, 32'hDEAD_BEEF, 32'hA000_0000};

    // Reset state
    mid();
    check_eq("rst_hready", 32'(m_hready), 32'd1);
    check_eq("rst_hresp", 32'(m_hresp), 32'd0);
    check_eq("rst_hrdata", m_hrdata, 32'h0);
    check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("rst_err_last", 32'(err_last), 32'd0);
    check_eq("rst_hsel", 32'(s_hsel), 32'd0);
    $display("txn reset");
    tick();
    rstn = 1'b1;
    tick();

    // Zero-wait read of slave 1
    m_haddr = 32'h1000_0004; m_haddr_ctrl = 1'b1; m_hwrite = 1'b0;
    mid();
    check_eq("rd1_hsel", 32'(s_hsel), 32'b0010);
    check_eq("rd1_haddr", s_haddr, 32'h1000_0004);
    tick();
    m_haddr_ctrl = 1'b0;
    mid();
    check_eq("rd1_hready", 32'(m_hready), 32'd1);
    check_eq("rd1_hresp", 32'(m_hresp), 32'd0);
    check_eq("rd1_hrdata", m_hrdata, 32'hDEAD_BEEF);
    $display("txn read 0x10000004");
    tick();

    // Write slave 0, then back-to-back read of slave 3 with 3 wait states
    m_haddr = 32'h0000_0000; m_haddr_ctrl = 1'b1; m_hwrite = 1'b1;
    mid();
    check_eq("b2b_hsel0", 32'(s_hsel), 32'b0001);
    check_eq("b2b_hwrite", 32'(s_hwrite), 32'd1);
    tick();
    m_haddr = 32'h3000_0010; m_hwrite = 1'b0; m_hwdata = 32'h1234_5678;
    mid();
    check_eq("b2b_hsel3", 32'(s_hsel), 32'b1000);
    check_eq("b2b_wr_hready", 32'(m_hready), 32'd1);
    check_eq("b2b_hwdata", s_hwdata, 32'h1234_5678);
    tick();
    m_haddr_ctrl = 1'b0; s_hready[3] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check_eq($sformatf("b2b_wait%0d", i), 32'(m_hready), 32'd0);
      tick();
    end
    s_hready[3] = 1'b1; s_hrdata[96 +: 32] = 32'hCAFE_0003;
    mid();
    check_eq("b2b_rd_hready", 32'(m_hready), 32'd1);
    check_eq("b2b_rd_hrdata", m_hrdata, 32'hCAFE_0003);
    $display("txn write 0x00000000 / read 0x30000010 waits=3");
    tick();

    // Unmapped read -> default slave ERROR
    m_haddr = 32'h5000_0000; m_haddr_ctrl = 1'b1;
    mid();
    check_eq("dec_hsel", 32'(s_hsel), 32'd0);
    tick();
    m_haddr_ctrl = 1'b0;
    mid();
    check_eq("dec_e1_hready", 32'(m_hready), 32'd0);
    check_eq("dec_e1_hresp", 32'(m_hresp), 32'd1);
    check_eq("dec_err_cnt", 32'(err_cnt), 32'd1);
    check_eq("dec_err_last", 32'(err_last), 32'd1);
    tick();
    mid();
    check_eq("dec_e2_hready", 32'(m_hready), 32'd1);
    check_eq("dec_e2_hresp", 32'(m_hresp), 32'd1);
    tick();
    mid();
    check_eq("dec_idle_hresp", 32'(m_hresp), 32'd0);
    $display("txn read 0x50000000 unmapped");

    // Slave 2 hangs -> timeout after 8 wait cycles
    tick();
    m_haddr = 32'h2000_0000; m_haddr_ctrl = 1'b1;
    mid();
    check_eq("to_hsel", 32'(s_hsel), 32'b0100);
    tick();
    m_haddr_ctrl = 1'b0; s_hready[2] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mid();
      check_eq($sformatf("to_wait%0d", i), 32'(m_hready), 32'd0);
      tick();
    end
    s_hready[2] = 1'b1;  // late ready from the hung slave
    mid();
    check_eq("to_e1_hready", 32'(m_hready), 32'd0);
    check_eq("to_e1_hresp", 32'(m_hresp), 32'd1);
    check_eq("to_err_cnt", 32'(err_cnt), 32'd2);
    check_eq("to_err_last", 32'(err_last), 32'd2);
    tick();
    s_hready[2] = 1'b0;
    mid();
    check_eq("to_e2_hready", 32'(m_hready), 32'd1);
    check_eq("to_e2_hresp", 32'(m_hresp), 32'd1);
    tick();
    s_hready[2] = 1'b1;
    mid();
    check_eq("to_idle_hready", 32'(m_hready), 32'd1);
    check_eq("to_idle_hresp", 32'(m_hresp), 32'd0);
    check_eq("to_idle_err_cnt", 32'(err_cnt), 32'd2);
    $display("txn read 0x20000000 timeout");
    tick();

    // Slave 0 ERROR passes through, not counted
    m_haddr = 32'h0000_0100; m_haddr_ctrl = 1'b1;
    tick();
    m_haddr_ctrl = 1'b0; s_hresp[0] = 1'b1;
    mid();
    check_eq("serr_hresp", 32'(m_hresp), 32'd1);
    check_eq("serr_hready", 32'(m_hready), 32'd1);
    tick();
    s_hresp[0] = 1'b0;
    mid();
    check_eq("serr_err_cnt", 32'(err_cnt), 32'd2);
    check_eq("serr_err_last", 32'(err_last), 32'd2);
    $display("txn read 0x00000100 slave error");
    tick();

    // Reset during a slave 1 wait state
    m_haddr = 32'h1000_0008; m_haddr_ctrl = 1'b1;
    tick();
    m_haddr_ctrl = 1'b0; s_hready[1] = 1'b0;
    mid();
    check_eq("mrst_wait", 32'(m_hready), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("mrst_hready", 32'(m_hready), 32'd1);
    check_eq("mrst_hresp", 32'(m_hresp), 32'd0);
    check_eq("mrst_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("mrst_err_last", 32'(err_last), 32'd0);
    tick();
    s_hready[1] = 1'b1;
    rstn = 1'b1;
    tick();
    m_haddr = 32'h1000_0004; m_haddr_ctrl = 1'b1;
    tick();
    m_haddr_ctrl = 1'b0;
    mid();
    check_eq("post_rst_hready", 32'(m_hready), 32'd1);
    check_eq("post_rst_hrdata", m_hrdata, 32'hDEAD_BEEF);
    $display("txn reset mid-transfer / read 0x10000004");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
